// File: rtl/mem_arbiter_ctrl.sv
// Round-robin arbiter between instruction-fetch and data-memory requesters onto
// a single-port RAM, with combinational wait/ack handshakes and an access watchdog.
module mem_arbiter_ctrl #(
  parameter int MAX_WAIT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramready,
  output logic        err
);

  localparam int CW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DACC = 2'd1,
    IACC = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_last_grant;
  logic          w_last_grant_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_err;
  logic          w_err_nxt;
  logic          w_dreq;
  logic          w_dack;
  logic          w_iack;

  assign w_dreq = dREN | dWEN;
  assign err    = r_err;

  // State, grant history, watchdog counter and sticky error flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_cnt        <= w_cnt_nxt;
      r_err        <= w_err_nxt;
    end
  end

  // Next-state, RAM strobes and handshake outputs.
  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_cnt_nxt        = r_cnt;
    w_err_nxt        = r_err;
    w_dack           = 1'b0;
    w_iack           = 1'b0;
    ramREN           = 1'b0;
    ramWEN           = 1'b0;
    ramaddr          = 32'h0000_0000;
    ramstore         = 32'h0000_0000;
    iload            = 32'h0000_0000;
    dload            = 32'h0000_0000;

    case (r_state)
      IDLE: begin
        // On contention the requester not granted last time wins.
        if (w_dreq && (!iREN || r_last_grant)) begin
          w_state_nxt      = DACC;
          w_last_grant_nxt = 1'b0;
          w_cnt_nxt        = '0;
        end else if (iREN) begin
          w_state_nxt      = IACC;
          w_last_grant_nxt = 1'b1;
          w_cnt_nxt        = '0;
        end else begin
          w_state_nxt      = IDLE;
        end
      end

      DACC: begin
        ramREN   = dREN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (!w_dreq) begin
          w_state_nxt = IDLE;
        end else if (ramready) begin
          w_dack      = 1'b1;
          dload       = ramload;
          w_state_nxt = IDLE;
        end else if (r_cnt == CNT_MAX) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt   = r_cnt + CW'(1);
        end
      end

      IACC: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        if (!iREN) begin
          w_state_nxt = IDLE;
        end else if (ramready) begin
          w_iack      = 1'b1;
          iload       = ramload;
          w_state_nxt = IDLE;
        end else if (r_cnt == CNT_MAX) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt   = r_cnt + CW'(1);
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    dwait = w_dreq & ~w_dack;
    iwait = iREN & ~w_iack;
  end

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Directed self-checking bench for mem_arbiter_ctrl (watchdog shortened to 4 cycles).
module tb_mem_arbiter_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ramready;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  mem_arbiter_ctrl #(.MAX_WAIT(4)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic        is_d;
    logic [31:0] exp_load;

    RST = 1'b1; iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0;
    iaddr = 32'h0000_0200; daddr = 32'h0000_0100; dstore = 32'h0000_55AA;
    ramload = 32'h0000_0000; ramready = 1'b0;
    #2;
    check_val("rst_ramREN", ramREN, 1'b0);
    check_val("rst_ramWEN", ramWEN, 1'b0);
    check_val("rst_iwait", iwait, 1'b1);
    check_val("rst_dwait", dwait, 1'b1);
    check_val("rst_err", err, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    ramready = 1'b1;

    // Contention: expected grant order D, I, D, I.
    for (int k = 0; k < 4; k++) begin
      exp_load = 32'hA5A5_0000 | 32'(k);
      ramload  = exp_load;
      is_d     = (k % 2 == 0);
      step();
      if (is_d) begin
        check_val("cont_d_ramREN", ramREN, (k == 0) ? 1'b1 : 1'b0);
        check_val("cont_d_ramWEN", ramWEN, (k == 2) ? 1'b1 : 1'b0);
        check_val("cont_d_addr", ramaddr, 32'h0000_0100);
        check_val("cont_d_store", ramstore, 32'h0000_55AA);
        check_val("cont_d_dwait", dwait, 1'b0);
        check_val("cont_d_dload", dload, exp_load);
        check_val("cont_d_iwait", iwait, 1'b1);
        check_val("cont_d_iload", iload, 32'h0000_0000);
      end else begin
        check_val("cont_i_ramREN", ramREN, 1'b1);
        check_val("cont_i_ramWEN", ramWEN, 1'b0);
        check_val("cont_i_addr", ramaddr, 32'h0000_0200);
        check_val("cont_i_iwait", iwait, 1'b0);
        check_val("cont_i_iload", iload, exp_load);
        check_val("cont_i_dwait", dwait, 1'b1);
        check_val("cont_i_dload", dload, 32'h0000_0000);
      end
      step();
      check_val("cont_idle_ramREN", ramREN, 1'b0);
      check_val("cont_idle_ramWEN", ramWEN, 1'b0);
      check_val("cont_idle_dwait", dwait, 1'b1);
      check_val("cont_idle_iwait", iwait, 1'b1);
      if (k == 0) begin
        dREN = 1'b0; dWEN = 1'b1;
      end else if (k == 2) begin
        dREN = 1'b1; dWEN = 1'b0;
      end else if (k == 3) begin
        dREN = 1'b0; dWEN = 1'b0; iREN = 1'b0;
      end
    end

    // Single load, zero RAM latency.
    dREN = 1'b1; daddr = 32'h0000_0040; ramload = 32'hDEAD_BEEF; ramready = 1'b1;
    #1;
    check_val("ld_c0_dwait", dwait, 1'b1);
    check_val("ld_c0_ramREN", ramREN, 1'b0);
    check_val("ld_c0_dload", dload, 32'h0000_0000);
    step();
    check_val("ld_c1_ramREN", ramREN, 1'b1);
    check_val("ld_c1_addr", ramaddr, 32'h0000_0040);
    check_val("ld_c1_dwait", dwait, 1'b0);
    check_val("ld_c1_dload", dload, 32'hDEAD_BEEF);
    step();
    check_val("ld_c2_ramREN", ramREN, 1'b0);
    check_val("ld_c2_dwait", dwait, 1'b1);
    check_val("ld_c2_dload", dload, 32'h0000_0000);
    dREN = 1'b0; ramready = 1'b0; ramload = 32'h0000_0000;

    // Store with 3-cycle RAM latency.
    dWEN = 1'b1; dstore = 32'h0000_1234; daddr = 32'h0000_0080;
    for (int c = 1; c <= 3; c++) begin
      step();
      if (c == 3) begin
        ramready = 1'b1;
        #1;
      end
      check_val("st_ramWEN", ramWEN, 1'b1);
      check_val("st_store", ramstore, 32'h0000_1234);
      check_val("st_addr", ramaddr, 32'h0000_0080);
      check_val("st_dwait", dwait, (c == 3) ? 1'b0 : 1'b1);
      check_val("st_dload", dload, 32'h0000_0000);
      check_val("st_iload", iload, 32'h0000_0000);
    end
    step();
    check_val("st_idle_ramWEN", ramWEN, 1'b0);
    dWEN = 1'b0; ramready = 1'b0;

    // Instruction flush during the second IACC cycle.
    iREN = 1'b1; iaddr = 32'h0000_0300;
    step();
    check_val("fl_c1_ramREN", ramREN, 1'b1);
    check_val("fl_c1_addr", ramaddr, 32'h0000_0300);
    check_val("fl_c1_iwait", iwait, 1'b1);
    step();
    check_val("fl_c2_ramREN_pre", ramREN, 1'b1);
    iREN = 1'b0; ramready = 1'b1; ramload = 32'h0000_CAFE;
    #1;
    check_val("fl_c2_ramREN", ramREN, 1'b0);
    check_val("fl_c2_iload", iload, 32'h0000_0000);
    check_val("fl_c2_iwait", iwait, 1'b0);
    step();
    iREN = 1'b1;
    #1;
    check_val("fl_idle_ramREN", ramREN, 1'b0);
    check_val("fl_idle_iwait", iwait, 1'b1);
    iREN = 1'b0; ramready = 1'b0; ramload = 32'h0000_0000;

    // Watchdog timeout after 4 DACC cycles without ramready.
    dREN = 1'b1; daddr = 32'h0000_0044;
    for (int c = 1; c <= 4; c++) begin
      step();
      check_val("to_ramREN", ramREN, 1'b1);
      check_val("to_err_low", err, 1'b0);
      check_val("to_dwait", dwait, 1'b1);
    end
    step();
    check_val("to_err_set", err, 1'b1);
    check_val("to_idle_ramREN", ramREN, 1'b0);
    check_val("to_idle_dwait", dwait, 1'b1);
    step();
    check_val("to_rearb_ramREN", ramREN, 1'b1);
    check_val("to_rearb_err", err, 1'b1);
    ramready = 1'b1; ramload = 32'h0000_0077;
    #1;
    check_val("to_rearb_dwait", dwait, 1'b0);
    check_val("to_rearb_dload", dload, 32'h0000_0077);
    step();
    dREN = 1'b0; ramready = 1'b0;
    step();
    check_val("to_err_sticky", err, 1'b1);
    RST = 1'b1;
    #1;
    check_val("to_err_cleared", err, 1'b0);
    RST = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
